// File: rtl/hififo_pkg.sv
// hififo_pkg: shared constants and helpers for the read-request scheduler.
// Holds the tag field layout, the scheduler FSM encoding and the tag builder.
package hififo_pkg;

    localparam int TAG_REQ_LSB = 3;
    localparam int TAG_REQ_W   = 2;
    localparam int TAG_SUB_W   = 3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    // PCIe tag layout: {3'b000, requester index, requester sub-tag}
    function automatic logic [7:0] make_tag(input logic [TAG_REQ_W-1:0] req,
                                            input logic [TAG_SUB_W-1:0] sub);
        make_tag = {3'b000, req, sub};
    endfunction

endpackage

// File: rtl/hififo_rr_credit.sv
// hififo_rr_credit: outstanding-request counter for one requester.
// Charges on TX acceptance, releases on a final completion, reports whether
// the requester may be granted and whether a release hit an empty counter.
module hififo_rr_credit #(
    parameter int MAX_OUT_PER = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic req_valid,
    input  logic charge,
    input  logic release_req,
    output logic eligible,
    output logic release_ok,
    output logic release_err
);

    localparam logic [3:0] LIMIT = 4'(MAX_OUT_PER);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign eligible    = req_valid & (cnt_q < LIMIT);
    assign release_ok  = release_req & (cnt_q != 4'd0);
    assign release_err = release_req & (cnt_q == 4'd0);

    // Net charge/release update; a simultaneous charge and release cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (charge && !release_ok) begin
            if (cnt_q < LIMIT) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (!charge && release_ok) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hififo_rr_sched.sv
// hififo_rr_sched: round-robin read-request scheduler between the four
// from-PC FIFO engines and the PCIe TX read-request port. Stamps each grant
// with an 8-bit tag and limits outstanding requests globally and per FIFO.
// Build macro HIFIFO_RR_SCHED_STATS_EN adds the 32-bit stats output
// (accepted-request count and outstanding high-water mark).
//
// Handshake: a grant decision is registered, so rri_ready pulses the cycle
// after the decision (the requester's head is still the captured one) and
// rro_valid rises one cycle after that pulse.
module hififo_rr_sched
    import hififo_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int MAX_OUT     = 8,
    parameter int MAX_OUT_PER = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  rri_valid,
    output logic [3:0]  rri_ready,
    input  logic [63:0] rri_addr_0,
    input  logic [63:0] rri_addr_1,
    input  logic [63:0] rri_addr_2,
    input  logic [63:0] rri_addr_3,
    input  logic [2:0]  rri_tag_0,
    input  logic [2:0]  rri_tag_1,
    input  logic [2:0]  rri_tag_2,
    input  logic [2:0]  rri_tag_3,
    output logic        rro_valid,
    input  logic        rro_ready,
    output logic [63:0] rro_addr,
    output logic [7:0]  rro_tag,
    input  logic        cpl_valid,
    input  logic [7:0]  cpl_tag,
    output logic [5:0]  outstanding,
`ifdef HIFIFO_RR_SCHED_STATS_EN
    output logic [31:0] stats,
`endif
    output logic        cpl_error
);

    localparam logic [5:0] MAX_OUT_C = 6'(MAX_OUT);

    logic        state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [3:0]  rri_ready_q, rri_ready_d;
    logic        rro_valid_q, rro_valid_d;
    logic [63:0] rro_addr_q, rro_addr_d;
    logic [7:0]  rro_tag_q, rro_tag_d;
    logic [5:0]  outstanding_q, outstanding_d;
    logic        cpl_error_q, cpl_error_d;

    logic [63:0] addr_arr_s [4];
    logic [2:0]  sub_arr_s [4];
    logic [3:0]  elig_s;
    logic [3:0]  cand_s;
    logic [3:0]  charge_s;
    logic [3:0]  release_s;
    logic [3:0]  rel_ok_s;
    logic [3:0]  rel_err_s;
    logic        global_ok_s;
    logic        grant_pend_s;
    logic        accept_s;
    logic        sel_found_s;
    logic [1:0]  sel_idx_s;
    logic [1:0]  cpl_req_s;
    logic        tag_hi_ok_s;
    logic        cpl_dec_s;
    logic [2:0]  cpl_sub_unused_s;

    assign addr_arr_s[0] = rri_addr_0;
    assign addr_arr_s[1] = rri_addr_1;
    assign addr_arr_s[2] = rri_addr_2;
    assign addr_arr_s[3] = rri_addr_3;
    assign sub_arr_s[0]  = rri_tag_0;
    assign sub_arr_s[1]  = rri_tag_1;
    assign sub_arr_s[2]  = rri_tag_2;
    assign sub_arr_s[3]  = rri_tag_3;

    // The sub-tag of a completion is not needed: credits are per requester.
    assign cpl_sub_unused_s = cpl_tag[2:0];
    assign cpl_req_s        = cpl_tag[TAG_REQ_LSB +: TAG_REQ_W];
    assign tag_hi_ok_s      = (cpl_tag[7:5] == 3'b000);

    assign global_ok_s  = (outstanding_q < MAX_OUT_C);
    assign cand_s       = elig_s & {4{global_ok_s}};
    assign grant_pend_s = |rri_ready_q;
    assign accept_s     = (state_q == ST_HOLD) & rro_valid_q & rro_ready;
    assign cpl_dec_s    = |rel_ok_s;

    // Route TX acceptance and completions to the owning credit counter.
    always_comb begin
        charge_s  = 4'b0000;
        release_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            charge_s[i]  = accept_s & (gnt_q == 2'(i));
            release_s[i] = cpl_valid & tag_hi_ok_s & (cpl_req_s == 2'(i));
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_credit
        hififo_rr_credit #(
            .MAX_OUT_PER (MAX_OUT_PER)
        ) u_credit (
            .clock       (clock),
            .reset_n     (reset_n),
            .req_valid   (rri_valid[gi]),
            .charge      (charge_s[gi]),
            .release_req (release_s[gi]),
            .eligible    (elig_s[gi]),
            .release_ok  (rel_ok_s[gi]),
            .release_err (rel_err_s[gi])
        );
    end

    // Pick the first eligible requester at or after the round-robin pointer.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!sel_found_s && cand_s[ptr_q + 2'(k)]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = ptr_q + 2'(k);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave IDLE once the grant pulse is out, leave HOLD on TX accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_pend_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (rro_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: grant decision, captured request, pointer advance.
    always_comb begin
        rri_ready_d = 4'b0000;
        gnt_d       = gnt_q;
        rro_addr_d  = rro_addr_q;
        rro_tag_d   = rro_tag_q;
        rro_valid_d = (state_d == ST_HOLD);
        if ((state_q == ST_IDLE) && !grant_pend_s && sel_found_s) begin
            rri_ready_d = 4'b0001 << sel_idx_s;
            gnt_d       = sel_idx_s;
            rro_addr_d  = addr_arr_s[sel_idx_s];
            rro_tag_d   = make_tag(sel_idx_s, sub_arr_s[sel_idx_s]);
        end else begin
            rri_ready_d = 4'b0000;
        end
        if (accept_s) begin
            ptr_d = gnt_q + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Global outstanding count and sticky completion error.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept_s && !cpl_dec_s) begin
            if (outstanding_q != 6'd63) begin
                outstanding_d = outstanding_q + 6'd1;
            end else begin
                outstanding_d = outstanding_q;
            end
        end else if (!accept_s && cpl_dec_s) begin
            if (outstanding_q != 6'd0) begin
                outstanding_d = outstanding_q - 6'd1;
            end else begin
                outstanding_d = outstanding_q;
            end
        end else begin
            outstanding_d = outstanding_q;
        end
        cpl_error_d = cpl_error_q | (cpl_valid & ~tag_hi_ok_s) | (|rel_err_s);
    end

    // Output, pointer and counter registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q         <= 2'd0;
            gnt_q         <= 2'd0;
            rri_ready_q   <= 4'b0000;
            rro_valid_q   <= 1'b0;
            rro_addr_q    <= 64'd0;
            rro_tag_q     <= 8'd0;
            outstanding_q <= 6'd0;
            cpl_error_q   <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            rri_ready_q   <= rri_ready_d;
            rro_valid_q   <= rro_valid_d;
            rro_addr_q    <= rro_addr_d;
            rro_tag_q     <= rro_tag_d;
            outstanding_q <= outstanding_d;
            cpl_error_q   <= cpl_error_d;
        end
    end

    assign rri_ready   = rri_ready_q;
    assign rro_valid   = rro_valid_q;
    assign rro_addr    = rro_addr_q;
    assign rro_tag     = rro_tag_q;
    assign outstanding = outstanding_q;
    assign cpl_error   = cpl_error_q;

`ifdef HIFIFO_RR_SCHED_STATS_EN
    logic [15:0] acc_cnt_q, acc_cnt_d;
    logic [5:0]  hwm_q, hwm_d;

    // Saturating accept counter and outstanding high-water mark.
    always_comb begin
        if (accept_s && (acc_cnt_q != 16'hFFFF)) begin
            acc_cnt_d = acc_cnt_q + 16'd1;
        end else begin
            acc_cnt_d = acc_cnt_q;
        end
        if (outstanding_d > hwm_q) begin
            hwm_d = outstanding_d;
        end else begin
            hwm_d = hwm_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_cnt_q <= 16'd0;
            hwm_q     <= 6'd0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
            hwm_q     <= hwm_d;
        end
    end

    assign stats = {10'd0, hwm_q, acc_cnt_q};
`endif

endmodule

// File: tb/tb_hififo_rr_sched.sv
// tb_hififo_rr_sched: directed bench for the read-request scheduler.
// The bench plays the four requesters, the TX port and the RX completion path,
// predicts every TX request in a scoreboard and tracks expected credit counts.
module tb_hififo_rr_sched;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  rri_valid;
    logic [3:0]  rri_ready;
    logic [63:0] head_addr [4];
    logic [2:0]  head_sub [4];
    logic        rro_valid;
    logic        rro_ready;
    logic [63:0] rro_addr;
    logic [7:0]  rro_tag;
    logic        cpl_valid;
    logic [7:0]  cpl_tag;
    logic [5:0]  outstanding;
    logic        cpl_error;
`ifdef HIFIFO_RR_SCHED_STATS_EN
    logic [31:0] stats_s;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [63:0] sb_addr_q [$];
    logic [7:0]  sb_tag_q [$];
    logic [7:0]  cpl_pend_q [$];
    int          grant_log [$];
    int          rem [4];
    int          m_cnt [4];
    int          m_out;
    logic        m_err;
    logic        auto_cpl;

    always #5 clock = ~clock;

    hififo_rr_sched dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rri_valid   (rri_valid),
        .rri_ready   (rri_ready),
        .rri_addr_0  (head_addr[0]),
        .rri_addr_1  (head_addr[1]),
        .rri_addr_2  (head_addr[2]),
        .rri_addr_3  (head_addr[3]),
        .rri_tag_0   (head_sub[0]),
        .rri_tag_1   (head_sub[1]),
        .rri_tag_2   (head_sub[2]),
        .rri_tag_3   (head_sub[3]),
        .rro_valid   (rro_valid),
        .rro_ready   (rro_ready),
        .rro_addr    (rro_addr),
        .rro_tag     (rro_tag),
        .cpl_valid   (cpl_valid),
        .cpl_tag     (cpl_tag),
        .outstanding (outstanding),
`ifdef HIFIFO_RR_SCHED_STATS_EN
        .stats       (stats_s),
`endif
        .cpl_error   (cpl_error)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_valid();
        for (int i = 0; i < 4; i++) rri_valid[i] = (rem[i] > 0);
    endtask

    // One clock: book the handshakes seen this cycle, cross the edge, then check.
    task automatic cyc();
        logic [3:0]  hs;
        logic [63:0] ea;
        logic [7:0]  et;
        int          cr;
        logic        cok;
        hs  = 4'b0000;
        cok = 1'b0;
        cr  = 0;
        if (!reset_n) begin
            sb_addr_q.delete();
            sb_tag_q.delete();
            cpl_pend_q.delete();
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0;
                rem[i]   = 0;
            end
            m_out = 0;
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rri_valid[i] && rri_ready[i]) begin
                    hs[i] = 1'b1;
                    sb_addr_q.push_back(head_addr[i]);
                    sb_tag_q.push_back({3'b000, 2'(i), head_sub[i]});
                    grant_log.push_back(i);
                end
            end
            if (cpl_valid) begin
                cr = int'(cpl_tag[4:3]);
                if ((cpl_tag[7:5] == 3'b000) && (m_cnt[cr] > 0)) cok = 1'b1;
                else m_err = 1'b1;
            end
            if (rro_valid && rro_ready) begin
                tests++;
                assert (sb_addr_q.size() > 0) else begin
                    fails++;
                    $error("FAIL sb_underflow: observed unexpected request addr %0h expected none", rro_addr);
                end
                if (sb_addr_q.size() > 0) begin
                    ea = sb_addr_q.pop_front();
                    et = sb_tag_q.pop_front();
                    check("sb_addr", rro_addr, ea);
                    check("sb_tag", {56'd0, rro_tag}, {56'd0, et});
                    m_cnt[et[4:3]]++;
                    m_out++;
                    if (auto_cpl) cpl_pend_q.push_back(et);
                end
            end
            if (cok) begin
                m_cnt[cr]--;
                m_out--;
            end
        end
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                rem[i]--;
                head_addr[i] = head_addr[i] + 64'h40;
                head_sub[i]  = head_sub[i] + 3'd1;
            end
        end
        set_valid();
        cpl_valid = 1'b0;
        if (auto_cpl && (cpl_pend_q.size() > 0)) begin
            cpl_valid = 1'b1;
            cpl_tag   = cpl_pend_q.pop_front();
        end
        check("outstanding", {58'd0, outstanding}, 64'(m_out));
        check("cpl_error", {63'd0, cpl_error}, {63'd0, m_err});
        check("ready_onehot0", {63'd0, $onehot0(rri_ready)}, 64'd1);
    endtask

    // Return every outstanding request recorded in the model.
    task automatic drain();
        for (int r = 0; r < 4; r++) begin
            while (m_cnt[r] > 0) begin
                cpl_valid = 1'b1;
                cpl_tag   = {3'b000, 2'(r), 3'b000};
                cyc();
            end
        end
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        rri_valid = 4'b0000;
        rro_ready = 1'b0;
        cpl_valid = 1'b0;
        cpl_tag   = 8'h00;
        auto_cpl  = 1'b0;
        m_out     = 0;
        m_err     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            head_addr[i] = 64'hA500_0000_0000_0000 | (64'(i + 1) << 16);
            head_sub[i]  = 3'(i);
            rem[i]       = 0;
            m_cnt[i]     = 0;
        end

        // Reset state.
        for (int i = 0; i < 3; i++) cyc();
        check("rst_rri_ready", {60'd0, rri_ready}, 64'd0);
        check("rst_rro_valid", {63'd0, rro_valid}, 64'd0);
        check("rst_rro_addr", rro_addr, 64'd0);
        check("rst_rro_tag", {56'd0, rro_tag}, 64'd0);
        check("rst_outstanding", {58'd0, outstanding}, 64'd0);
        check("rst_cpl_error", {63'd0, cpl_error}, 64'd0);
        reset_n = 1'b1;

        // Single request from requester 1.
        head_addr[1] = 64'h1000;
        head_sub[1]  = 3'd5;
        rem[1]       = 1;
        rro_ready    = 1'b1;
        set_valid();
        n = 0;
        while ((rri_ready == 4'b0000) && (n < 5)) begin cyc(); n++; end
        check("s1_ready_pulse", {60'd0, rri_ready}, 64'h2);
        cyc();
        check("s1_ready_drop", {60'd0, rri_ready}, 64'd0);
        check("s1_rro_valid", {63'd0, rro_valid}, 64'd1);
        check("s1_rro_addr", rro_addr, 64'h1000);
        check("s1_rro_tag", {56'd0, rro_tag}, 64'h0D);
        cyc();
        check("s1_outstanding", {58'd0, outstanding}, 64'd1);
        check("s1_valid_clear", {63'd0, rro_valid}, 64'd0);
        cpl_valid = 1'b1;
        cpl_tag   = 8'h0D;
        cyc();
        check("s1_released", {58'd0, outstanding}, 64'd0);

        // Fairness: everyone valid, immediate completions; pointer sits at 2.
        grant_log.delete();
        auto_cpl = 1'b1;
        for (int i = 0; i < 4; i++) rem[i] = 2;
        set_valid();
        n = 0;
        while ((grant_log.size() < 8) && (n < 200)) begin cyc(); n++; end
        check("s2_grants_done", 64'(grant_log.size()), 64'd8);
        if (grant_log.size() == 8) begin
            check("s2_first_grant", 64'(grant_log[0]), 64'd2);
            for (int k = 1; k < 8; k++)
                check("s2_rr_order", 64'(grant_log[k]), 64'((grant_log[k-1] + 1) % 4));
        end
        n = 0;
        while (((m_out != 0) || (cpl_pend_q.size() > 0) || (sb_addr_q.size() > 0)) && (n < 50)) begin cyc(); n++; end
        auto_cpl = 1'b0;
        cyc();
        check("s2_drained", {58'd0, outstanding}, 64'd0);

        // Global limit of 8 with 9 requests and no completions.
        rem[0] = 3; rem[1] = 3; rem[2] = 3;
        set_valid();
        n = 0;
        while ((m_out < 8) && (n < 100)) begin cyc(); n++; end
        check("s3_at_limit", {58'd0, outstanding}, 64'd8);
        for (int k = 0; k < 20; k++) begin
            cyc();
            check("s3_no_valid", {63'd0, rro_valid}, 64'd0);
            check("s3_no_grant", {60'd0, rri_ready}, 64'd0);
        end
        cpl_valid = 1'b1;
        cpl_tag   = 8'h08;
        cyc();
        check("s3_after_cpl", {58'd0, outstanding}, 64'd7);
        n = 0;
        while ((rri_ready == 4'b0000) && (n < 3)) begin cyc(); n++; end
        check("s3_regrant", {60'd0, rri_ready & rri_valid}, {60'd0, rri_ready});
        check("s3_regrant_time", 64'(n < 3), 64'd1);
        n = 0;
        while ((m_out < 8) && (n < 10)) begin cyc(); n++; end
        check("s3_refill", {58'd0, outstanding}, 64'd8);
        drain();
        check("s3_drained", {58'd0, outstanding}, 64'd0);

        // Per-requester limit on requester 2, then requester 0 gets through.
        rem[2] = 6;
        set_valid();
        n = 0;
        while ((m_cnt[2] < 4) && (n < 60)) begin cyc(); n++; end
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("s4_req2_blocked", {60'd0, rri_ready}, 64'd0);
        end
        check("s4_outstanding", {58'd0, outstanding}, 64'd4);
        rem[0] = 1;
        set_valid();
        n = 0;
        while ((rri_ready == 4'b0000) && (n < 5)) begin cyc(); n++; end
        check("s4_req0_granted", {60'd0, rri_ready}, 64'h1);
        n = 0;
        while ((m_out < 5) && (n < 5)) begin cyc(); n++; end
        check("s4_outstanding5", {58'd0, outstanding}, 64'd5);
        rem[2] = 0;
        set_valid();
        drain();

        // Backpressure stability, then accept and completion on the same cycle.
        rem[3] = 1;
        set_valid();
        n = 0;
        while ((m_cnt[3] < 1) && (n < 10)) begin cyc(); n++; end
        rro_ready = 1'b0;
        rem[3]    = 1;
        set_valid();
        n = 0;
        while (!rro_valid && (n < 10)) begin cyc(); n++; end
        check("s5_hold_valid", {63'd0, rro_valid}, 64'd1);
        if (sb_addr_q.size() > 0) begin
            for (int k = 0; k < 10; k++) begin
                cyc();
                check("s5_valid_stable", {63'd0, rro_valid}, 64'd1);
                check("s5_addr_stable", rro_addr, sb_addr_q[0]);
                check("s5_tag_stable", {56'd0, rro_tag}, {56'd0, sb_tag_q[0]});
            end
        end
        rro_ready = 1'b1;
        cpl_valid = 1'b1;
        cpl_tag   = 8'h18;
        cyc();
        check("s5_simul_net", {58'd0, outstanding}, 64'd1);
        check("s5_simul_noerr", {63'd0, cpl_error}, 64'd0);

        // Error: completion for requester 3 once its count is zero.
        cpl_valid = 1'b1;
        cpl_tag   = 8'h18;
        cyc();
        check("s6_last_release", {58'd0, outstanding}, 64'd0);
        cpl_valid = 1'b1;
        cpl_tag   = 8'h18;
        cyc();
        check("s6_cpl_error", {63'd0, cpl_error}, 64'd1);
        check("s6_no_change", {58'd0, outstanding}, 64'd0);

        // Reset while a request is held.
        rro_ready = 1'b0;
        rem[0]    = 1;
        set_valid();
        n = 0;
        while (!rro_valid && (n < 10)) begin cyc(); n++; end
        check("s7_in_hold", {63'd0, rro_valid}, 64'd1);
        reset_n = 1'b0;
        cyc();
        check("s7_rst_valid", {63'd0, rro_valid}, 64'd0);
        check("s7_rst_outstanding", {58'd0, outstanding}, 64'd0);
        check("s7_rst_error", {63'd0, cpl_error}, 64'd0);
        check("s7_rst_ready", {60'd0, rri_ready}, 64'd0);
        reset_n = 1'b1;

        // Pointer restarts at 0 after reset.
        grant_log.delete();
        rro_ready = 1'b1;
        for (int i = 0; i < 4; i++) rem[i] = 1;
        set_valid();
        n = 0;
        while ((m_out < 4) && (n < 40)) begin cyc(); n++; end
        check("s7_grants", 64'(grant_log.size()), 64'd4);
        for (int k = 0; k < grant_log.size(); k++)
            check("s7_order", 64'(grant_log[k]), 64'(k));

        // Nonzero upper tag bits flag an error without touching counts.
        cpl_valid = 1'b1;
        cpl_tag   = 8'hE0;
        cyc();
        check("s8_hibits_error", {63'd0, cpl_error}, 64'd1);
        check("s8_hibits_count", {58'd0, outstanding}, 64'd4);
        drain();
        check("s8_drained", {58'd0, outstanding}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
